fetch_queue: RTL and testbench

- Dual-issue instruction buffer between the fetch stage and decode.
- Accepts up to two fetched instructions per cycle (PC plus instruction word) and presents up to two in program order to decode.
- Drives the per-slot proceed signals back to fetch. When a control-flow redirect occurs, it flushes all buffered entries.

---
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch/decode-facing bundle of the dual-issue fetch queue.
// master = fetch + decode side, slave = the queue itself.
interface fetch_queue_if #(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic             flush;
   logic [1:0]       in_valid;
   logic [1:0][31:0] in_pc;
   logic [1:0][31:0] in_instr;
   logic [1:0]       can_proceed;
   logic [1:0]       out_valid;
   logic [1:0][31:0] out_pc;
   logic [1:0][31:0] out_instr;
   logic [1:0]       deq_ready;
   logic [AW:0]      occupancy;

   modport master (
      output flush, in_valid, in_pc, in_instr, deq_ready,
      input  can_proceed, out_valid, out_pc, out_instr, occupancy
   );

   modport slave (
      input  flush, in_valid, in_pc, in_instr, deq_ready,
      output can_proceed, out_valid, out_pc, out_instr, occupancy
   );
endinterface

// File: rtl/fetch_queue.sv
// Dual-issue in-order instruction buffer between fetch and decode.
// Circular buffer; redirect flush empties it; no empty bypass (1-cycle latency).
module fetch_queue #(
   parameter int unsigned DEPTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   fetch_queue_if.slave  fq
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0] head_q, head_d, head_p1;
   logic [AW-1:0] tail_q, tail_d, tail_p1;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [1:0]    room;
   logic [1:0]    vld;
   logic [1:0]    wr_en;
   logic [1:0]    rd_en;
   logic [1:0]    n_in;
   logic [1:0]    n_out;

   assign head_p1 = head_q + AW'(1);
   assign tail_p1 = tail_q + AW'(1);

   // Free-slot and valid decodes use registered count only: no path from deq_ready.
   assign room[0] = (count_q < CW'(DEPTH));
   assign room[1] = (count_q < CW'(DEPTH - 1));
   assign vld[0]  = (count_q != '0);
   assign vld[1]  = (count_q >= CW'(2));

   always_comb begin
      wr_en   = '0;
      rd_en   = '0;
      n_in    = '0;
      n_out   = '0;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (fq.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // Slot 1 only rides along with slot 0, on both the write and read sides.
         wr_en[0] = fq.in_valid[0] & room[0];
         wr_en[1] = wr_en[0] & fq.in_valid[1] & room[1];
         rd_en[0] = fq.deq_ready[0] & vld[0];
         rd_en[1] = rd_en[0] & fq.deq_ready[1] & vld[1];
         n_in     = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
         n_out    = {1'b0, rd_en[0]} + {1'b0, rd_en[1]};
         tail_d   = tail_q + AW'(n_in);
         head_d   = head_q + AW'(n_out);
         count_d  = count_q + CW'(n_in) - CW'(n_out);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (wr_en[0]) begin
         pc_mem[tail_q]    <= fq.in_pc[0];
         instr_mem[tail_q] <= fq.in_instr[0];
      end
      if (wr_en[1]) begin
         pc_mem[tail_p1]    <= fq.in_pc[1];
         instr_mem[tail_p1] <= fq.in_instr[1];
      end
   end

   assign fq.can_proceed  = room;
   assign fq.out_valid    = vld;
   assign fq.occupancy    = count_q;
   assign fq.out_pc[0]    = pc_mem[head_q];
   assign fq.out_pc[1]    = pc_mem[head_p1];
   assign fq.out_instr[0] = instr_mem[head_q];
   assign fq.out_instr[1] = instr_mem[head_p1];

   // Fetch protocol: slot 1 never alone, and never deliver beyond advertised room.
   a_slot1_alone: assert property (@(posedge clk) disable iff (!reset)
      !(fq.in_valid[1] && !fq.in_valid[0]));
   a_overflow: assert property (@(posedge clk) disable iff (!reset)
      !((fq.in_valid[0] && !room[0]) || (fq.in_valid[0] && fq.in_valid[1] && !room[1])));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model checked every cycle.
module tb_fetch_queue;
   localparam int unsigned DEPTH = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic clk;
   logic reset;
   logic run;
   int   total;
   int   bad;
   ent_t mq[$];

   fetch_queue_if #(.DEPTH(DEPTH)) fq ();

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .fq    (fq.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ins(input logic [31:0] pc);
      return {~pc[15:0], pc[15:0]} ^ 32'h1357_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: in-order queue, popped by decode handshake, pushed by fetch.
   task automatic model_update(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic [1:0] dr, input logic fl);
      int old;
      int k;
      ent_t e;
      old = mq.size();
      k = 0;
      if (dr[0] && old >= 1) k = 1;
      if (k == 1 && dr[1] && old >= 2) k = 2;
      if (fl) begin
         mq.delete();
      end else begin
         for (int i = 0; i < k; i++) void'(mq.pop_front());
         if (v[0] && old < int'(DEPTH)) begin
            e.pc = pc0; e.instr = ins(pc0); mq.push_back(e);
         end
         if (v[0] && v[1] && old < int'(DEPTH) - 1) begin
            e.pc = pc1; e.instr = ins(pc1); mq.push_back(e);
         end
      end
   endtask

   // One clock: drive at negedge, model follows the rising edge, return at next negedge.
   task automatic step(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] dr, input logic fl);
      fq.in_valid    = v;
      fq.in_pc[0]    = pc0;
      fq.in_pc[1]    = pc1;
      fq.in_instr[0] = ins(pc0);
      fq.in_instr[1] = ins(pc1);
      fq.deq_ready   = dr;
      fq.flush       = fl;
      @(posedge clk);
      model_update(v, pc0, pc1, dr, fl);
      @(negedge clk);
   endtask

   task automatic idle();
      step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < int'(DEPTH); i++) step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
   endtask

   always @(negedge clk) begin
      int n;
      if (run) begin
         n = mq.size();
         check("occupancy", 64'(fq.occupancy), 64'(n));
         check("out_valid", 64'(fq.out_valid), 64'({n >= 2, n >= 1}));
         check("can_proceed", 64'(fq.can_proceed),
               64'({int'(DEPTH) - n >= 2, int'(DEPTH) - n >= 1}));
         if (n >= 1) begin
            check("out_pc0", 64'(fq.out_pc[0]), 64'(mq[0].pc));
            check("out_instr0", 64'(fq.out_instr[0]), 64'(mq[0].instr));
         end
         if (n >= 2) begin
            check("out_pc1", 64'(fq.out_pc[1]), 64'(mq[1].pc));
            check("out_instr1", 64'(fq.out_instr[1]), 64'(mq[1].instr));
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      run   = 1'b0;
      reset = 1'b0;
      fq.flush = 1'b0; fq.in_valid = '0; fq.deq_ready = '0;
      fq.in_pc = '0; fq.in_instr = '0;
      repeat (2) @(negedge clk);
      check("rst_occupancy", 64'(fq.occupancy), 64'd0);
      check("rst_out_valid", 64'(fq.out_valid), 64'd0);
      check("rst_can_proceed", 64'(fq.can_proceed), 64'd3);
      reset = 1'b1;
      run   = 1'b1;
      idle();

      // Fill to full with dual enqueues
      for (int i = 0; i < 4; i++) step(2'b11, 32'(i * 8), 32'(i * 8 + 4), 2'b00, 1'b0);
      check("fill_occupancy", 64'(fq.occupancy), 64'd8);
      check("fill_can_proceed", 64'(fq.can_proceed), 64'd0);
      check("fill_out_valid", 64'(fq.out_valid), 64'd3);
      check("fill_pc0", 64'(fq.out_pc[0]), 64'h0);
      check("fill_pc1", 64'(fq.out_pc[1]), 64'h4);
      drain();

      // DEPTH-1 boundary, then a single-slot enqueue to full
      for (int i = 0; i < 3; i++) step(2'b11, 32'h200 + 32'(i * 8), 32'h204 + 32'(i * 8), 2'b00, 1'b0);
      step(2'b01, 32'h218, 32'h0, 2'b00, 1'b0);
      check("b7_occupancy", 64'(fq.occupancy), 64'd7);
      check("b7_can_proceed", 64'(fq.can_proceed), 64'b01);
      step(2'b01, 32'h100, 32'h0, 2'b00, 1'b0);
      check("b8_occupancy", 64'(fq.occupancy), 64'd8);
      for (int i = 0; i < 3; i++) step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
      check("b_tail_pc0", 64'(fq.out_pc[0]), 64'h218);
      check("b_tail_pc1", 64'(fq.out_pc[1]), 64'h100);
      drain();

      // Steady dual in / dual out across pointer wrap
      step(2'b11, 32'h1000, 32'h1004, 2'b00, 1'b0);
      step(2'b11, 32'h1008, 32'h100C, 2'b00, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check("wrap_pc0", 64'(fq.out_pc[0]), 64'(32'h1000 + 32'(i * 8)));
         check("wrap_occupancy", 64'(fq.occupancy), 64'd4);
         step(2'b11, 32'h1010 + 32'(i * 8), 32'h1014 + 32'(i * 8), 2'b11, 1'b0);
      end
      check("wrap_end_pc0", 64'(fq.out_pc[0]), 64'h1050);
      drain();

      // Partial dequeue, then the out-of-order request that must consume nothing
      step(2'b11, 32'h300, 32'h304, 2'b00, 1'b0);
      step(2'b01, 32'h308, 32'h0, 2'b00, 1'b0);
      step(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
      check("part_pc0", 64'(fq.out_pc[0]), 64'h304);
      check("part_occupancy", 64'(fq.occupancy), 64'd2);
      step(2'b01, 32'h30C, 32'h0, 2'b00, 1'b0);
      step(2'b00, 32'h0, 32'h0, 2'b10, 1'b0);
      check("ooo_occupancy", 64'(fq.occupancy), 64'd3);
      check("ooo_pc0", 64'(fq.out_pc[0]), 64'h304);
      drain();

      // Flush beats same-cycle enqueue and dequeue
      step(2'b11, 32'h400, 32'h404, 2'b00, 1'b0);
      step(2'b11, 32'h408, 32'h40C, 2'b00, 1'b0);
      step(2'b01, 32'h410, 32'h0, 2'b00, 1'b0);
      step(2'b11, 32'h414, 32'h418, 2'b11, 1'b1);
      check("flush_occupancy", 64'(fq.occupancy), 64'd0);
      check("flush_out_valid", 64'(fq.out_valid), 64'd0);
      check("flush_can_proceed", 64'(fq.can_proceed), 64'd3);
      step(2'b01, 32'h2000, 32'h0, 2'b00, 1'b0);
      check("post_flush_pc0", 64'(fq.out_pc[0]), 64'h2000);
      check("post_flush_valid", 64'(fq.out_valid), 64'b01);
      drain();

      // Asynchronous reset between clock edges
      for (int i = 0; i < 3; i++) step(2'b11, 32'h500 + 32'(i * 8), 32'h504 + 32'(i * 8), 2'b00, 1'b0);
      check("pre_rst_occupancy", 64'(fq.occupancy), 64'd6);
      fq.in_valid = '0;
      #2;
      reset = 1'b0;
      mq.delete();
      #1;
      check("arst_occupancy", 64'(fq.occupancy), 64'd0);
      check("arst_out_valid", 64'(fq.out_valid), 64'd0);
      check("arst_can_proceed", 64'(fq.can_proceed), 64'd3);
      @(negedge clk);
      reset = 1'b1;
      step(2'b01, 32'h40, 32'h0, 2'b00, 1'b0);
      check("post_rst_pc0", 64'(fq.out_pc[0]), 64'h40);
      check("post_rst_instr0", 64'(fq.out_instr[0]), 64'(ins(32'h40)));
      drain();
      idle();

      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
